verifla_capture_rle: RTL and testbench

VERIFLA_CAPTURE_RLE -- requirements
Module: verifla_capture_rle

---
 rtl/verifla_pkg.sv | 25 ++
 rtl/verifla_rle_stage.sv | 63 ++++++
 rtl/verifla_capture_rle.sv | 194 +++++++++++++++++++
 tb/tb_verifla_capture_rle.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verifla_pkg.sv
// Shared definitions for the VeriFLA run-length-encoded capture engine.
// Holds the capture FSM state encoding, the capture-line layout constants
// and the default values of the capture parameters.
package verifla_pkg;

    // Default capture parameters
    localparam int unsigned DATA_W_DEF    = 16;  // probed sample width
    localparam int unsigned REP_W_DEF     = 8;   // repetition field width
    localparam int unsigned ADDR_W_DEF    = 6;   // capture RAM address width
    localparam int unsigned PRE_LINES_DEF = 8;   // pre-trigger ring size

    // Capture line layout: line = {rep, data}; rep occupies the upper REP_W bits.
    localparam int unsigned LINE_DATA_LSB = 0;
    // Bookkeeping line (last address): rep = 0, data = {wrapped, last_pre}.
    localparam int unsigned BOOK_REP      = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_POST = 3'd2,
        ST_BOOK = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage : verifla_pkg

// File: rtl/verifla_rle_stage.sv
// Run-length encoder stage: tracks the current run (held value + repeat count)
// and reports combinationally when the run must be emitted as a capture line.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load_i       start a new run from sample_i (capture start)
//   active_i     compare/count enable (capture phases)
//   flush_i      force emission of the pending run (trigger cycle)
//   sample_i     probed sample
//   emit_c       pending run must be written this cycle (combinational)
//   line_c       pending line {rep, held} (combinational)
module verifla_rle_stage
    import verifla_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REP_W  = REP_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic                    active_i,
    input  logic                    flush_i,
    input  logic [DATA_W-1:0]       sample_i,
    output logic                    emit_c,
    output logic [REP_W+DATA_W-1:0] line_c
);

    localparam logic [REP_W-1:0] REP_MAX = '1;
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    logic [DATA_W-1:0] held_q, held_d;
    logic [REP_W-1:0]  rep_q,  rep_d;
    logic              differ;
    logic              sat;

    // Emit decision and next run state
    always_comb begin
        differ = (sample_i != held_q);
        sat    = (rep_q == REP_MAX);
        emit_c = active_i & (flush_i | differ | sat);
        line_c = {rep_q, held_q};
        held_d = held_q;
        rep_d  = rep_q;
        if (load_i || emit_c) begin
            // emitted run (including a saturated one) restarts from this sample
            held_d = sample_i;
            rep_d  = REP_ONE;
        end else if (active_i) begin
            rep_d  = rep_q + REP_ONE;
        end
    end

    // Run registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= '0;
            rep_q  <= '0;
        end else begin
            held_q <= held_d;
            rep_q  <= rep_d;
        end
    end

endmodule : verifla_rle_stage

// File: rtl/verifla_capture_rle.sv
// VeriFLA capture controller with run-length encoding.
// A pre-trigger ring (addresses 0..PRE_LINES-1) records RLE lines until the
// trigger; post-trigger lines fill PRE_LINES..DEPTH-2; the last line holds
// {rep=0, wrapped, last_pre} so software can unroll the ring.
// Ports:
//   clk_of_verifla, rst_l         clock, async active-low reset
//   arm                           start pulse (honoured in IDLE/DONE only)
//   sample                        probed signals
//   trig_value, trig_mask         trigger compare value and care mask
//   trig_edge                     0 = level match, 1 = rising match only
//   mem_we, mem_addr, mem_wdata   capture RAM write port, wdata = {rep, data}
//   busy, la_trigger_matched, done  status
module verifla_capture_rle
    import verifla_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned REP_W     = REP_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned PRE_LINES = PRE_LINES_DEF
) (
    input  logic                    clk_of_verifla,
    input  logic                    rst_l,
    input  logic                    arm,
    input  logic [DATA_W-1:0]       sample,
    input  logic [DATA_W-1:0]       trig_value,
    input  logic [DATA_W-1:0]       trig_mask,
    input  logic                    trig_edge,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [REP_W+DATA_W-1:0] mem_wdata,
    output logic                    busy,
    output logic                    la_trigger_matched,
    output logic                    done
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned LINE_W = REP_W + DATA_W;

    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] RING_LAST  = ADDR_W'(PRE_LINES - 1);
    localparam logic [ADDR_W-1:0] POST_FIRST = ADDR_W'(PRE_LINES);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;            // next line address
    logic [ADDR_W-1:0]   last_pre_q, last_pre_d;  // address of the trigger flush
    logic                wrapped_q, wrapped_d;
    logic                prev_match_q, prev_match_d;
    logic                trig_q, trig_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                match_c;
    logic                arm_ok_c;
    logic                fire_c;
    logic                post_end_c;
    logic                rle_active_c;
    logic                emit_c;
    logic [LINE_W-1:0]   line_c;

    // Trigger qualification and RLE enables
    always_comb begin
        match_c      = (((sample ^ trig_value) & trig_mask) == '0);
        arm_ok_c     = arm && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        fire_c       = (state_q == ST_PRE) && match_c && (!trig_edge || !prev_match_q);
        // next address past DEPTH-2 means the post area is full
        post_end_c   = (state_q == ST_POST) && (ptr_q == ADDR_LAST);
        rle_active_c = (state_q == ST_PRE) || ((state_q == ST_POST) && !post_end_c);
    end

    verifla_rle_stage #(
        .DATA_W (DATA_W),
        .REP_W  (REP_W)
    ) u_rle (
        .clk      (clk_of_verifla),
        .rst_n    (rst_l),
        .load_i   (arm_ok_c),
        .active_i (rle_active_c),
        .flush_i  (fire_c),
        .sample_i (sample),
        .emit_c   (emit_c),
        .line_c   (line_c)
    );

    // Next state, address generation and registered-output next values
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        last_pre_d   = last_pre_q;
        wrapped_d    = wrapped_q;
        prev_match_d = prev_match_q;
        trig_d       = trig_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_ok_c) begin
                    state_d      = ST_PRE;
                    ptr_d        = '0;
                    wrapped_d    = 1'b0;
                    last_pre_d   = '0;
                    prev_match_d = 1'b1;  // edge mode must not fire on the first cycle
                    trig_d       = 1'b0;
                end
            end
            ST_PRE: begin
                prev_match_d = match_c;
                if (emit_c) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = line_c;
                end
                if (fire_c) begin
                    last_pre_d = ptr_q;
                    ptr_d      = POST_FIRST;
                    trig_d     = 1'b1;
                    state_d    = ST_POST;
                end else if (emit_c) begin
                    if (ptr_q == RING_LAST) begin
                        ptr_d     = '0;
                        wrapped_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + ADDR_ONE;
                    end
                end
            end
            ST_POST: begin
                if (post_end_c) begin
                    // partial run is dropped; write the bookkeeping line
                    we_d    = 1'b1;
                    addr_d  = ADDR_LAST;
                    wdata_d = {REP_W'(BOOK_REP), wrapped_q, (DATA_W - 1)'(last_pre_q)};
                    state_d = ST_BOOK;
                end else if (emit_c) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = line_c;
                    ptr_d   = ptr_q + ADDR_ONE;
                end
            end
            ST_BOOK: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_PRE) || (state_d == ST_POST) || (state_d == ST_BOOK);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk_of_verifla or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            last_pre_q   <= '0;
            wrapped_q    <= 1'b0;
            prev_match_q <= 1'b0;
            trig_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            last_pre_q   <= last_pre_d;
            wrapped_q    <= wrapped_d;
            prev_match_q <= prev_match_d;
            trig_q       <= trig_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign mem_we             = we_q;
    assign mem_addr           = addr_q;
    assign mem_wdata          = wdata_q;
    assign busy               = busy_q;
    assign la_trigger_matched = trig_q;
    assign done               = done_q;

endmodule : verifla_capture_rle

// File: tb/tb_verifla_capture_rle.sv
// Self-checking bench for verifla_capture_rle (16-bit samples, 8-bit rep,
// 64-line RAM, 8-line pre-trigger ring). A shadow RAM records every write;
// a sample-level reference model predicts the final RAM image.
module tb_verifla_capture_rle;

    localparam int unsigned DW    = 16;
    localparam int unsigned RW    = 8;
    localparam int unsigned AW    = 6;
    localparam int unsigned PRE   = 8;
    localparam int unsigned DEPTH = 64;
    localparam int          MAXC  = 2048;
    localparam logic [23:0] SENT  = 24'hA5A5A5;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          arm;
    logic [DW-1:0] sample;
    logic [DW-1:0] trig_value;
    logic [DW-1:0] trig_mask;
    logic          trig_edge;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_wdata;
    logic          busy;
    logic          la_trigger_matched;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus tables and trigger configuration for one capture
    logic [15:0] s    [MAXC];
    logic [15:0] tv   [MAXC];
    bit          armx [MAXC];
    logic [15:0] t_mask;
    bit          t_edge;

    // model results
    logic [23:0] exp_mem [DEPTH];
    int m_kt, m_kdone, m_nwr;

    // observed RAM
    logic [23:0] shadow [DEPTH];
    int nwr;
    int first_addr;

    verifla_capture_rle #(
        .DATA_W    (DW),
        .REP_W     (RW),
        .ADDR_W    (AW),
        .PRE_LINES (PRE)
    ) dut (
        .clk_of_verifla     (clk),
        .rst_l              (rst_l),
        .arm                (arm),
        .sample             (sample),
        .trig_value         (trig_value),
        .trig_mask          (trig_mask),
        .trig_edge          (trig_edge),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .busy               (busy),
        .la_trigger_matched (la_trigger_matched),
        .done               (done)
    );

    always #5 clk = ~clk;

    // RAM write port monitor
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            shadow[mem_addr] = mem_wdata;
            nwr = nwr + 1;
            if (first_addr < 0) first_addr = int'(mem_addr);
        end
    end

    // Reference model: sample k is the value present at the k-th edge after
    // (and including, k = 0) the arm edge.
    task automatic model_run();
        logic [15:0] held;
        int rep, ptr, lastp;
        bit wr, prevm, post, m, fire;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = SENT;
        m_kt = -1; m_kdone = -1; m_nwr = 0;
        held = s[0]; rep = 1; ptr = 0; lastp = 0; wr = 0; prevm = 1; post = 0;
        for (int k = 1; k < MAXC; k++) begin
            if (!post) begin
                m     = (((s[k] ^ tv[k]) & t_mask) == 16'h0);
                fire  = m && (!t_edge || !prevm);
                prevm = m;
                if (fire) begin
                    exp_mem[ptr] = {8'(rep), held}; m_nwr++;
                    lastp = ptr; ptr = PRE; post = 1; m_kt = k;
                    held = s[k]; rep = 1;
                end else if (s[k] == held && rep < 255) begin
                    rep++;
                end else begin
                    exp_mem[ptr] = {8'(rep), held}; m_nwr++;
                    ptr = (ptr + 1) % PRE;
                    if (ptr == 0) wr = 1;
                    held = s[k]; rep = 1;
                end
            end else if (ptr == DEPTH - 1) begin
                exp_mem[DEPTH-1] = {8'h00, wr, 15'(lastp)}; m_nwr++;
                m_kdone = k + 1;
                break;
            end else if (s[k] == held && rep < 255) begin
                rep++;
            end else begin
                exp_mem[ptr] = {8'(rep), held}; m_nwr++;
                ptr++;
                held = s[k]; rep = 1;
            end
        end
    endtask

    task automatic fill_random(input int alpha, input logic [15:0] tval);
        for (int k = 0; k < MAXC; k++) begin
            s[k]    = 16'h1000 + 16'($urandom_range(0, alpha - 1)) * 16'h0111;
            tv[k]   = tval;
            armx[k] = 1'b0;
        end
    endtask

    // Drive one capture from the tables and compare against the model.
    task automatic run_capture(input string name);
        int obs_kt, obs_kd, busy_bad;
        model_run();
        for (int i = 0; i < DEPTH; i++) shadow[i] = SENT;
        obs_kt = -1; obs_kd = -1; busy_bad = 0;
        trig_mask = t_mask;
        trig_edge = t_edge;
        @(negedge clk);
        nwr = 0; first_addr = -1;
        for (int k = 0; k < MAXC; k++) begin
            arm        = (k == 0) || armx[k];
            sample     = s[k];
            trig_value = tv[k];
            @(posedge clk);
            @(negedge clk);
            if (la_trigger_matched === 1'b1 && obs_kt < 0) obs_kt = k;
            if (done === 1'b1 && obs_kd < 0) obs_kd = k;
            if (busy !== ((m_kdone < 0) || (k < m_kdone))) busy_bad++;
            if (obs_kd >= 0 && k >= obs_kd + 3) break;
        end
        arm = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (shadow[i] !== exp_mem[i]) begin
                n_errors++;
                $display("FAIL %s line[%0d]: got %h expected %h", name, i, shadow[i], exp_mem[i]);
            end
        end
        n_checks++;
        if (obs_kt !== m_kt) begin
            n_errors++;
            $display("FAIL %s trigger_cycle: got %0d expected %0d", name, obs_kt, m_kt);
        end
        n_checks++;
        if (obs_kd !== m_kdone) begin
            n_errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d (bound %0d cycles)", name, obs_kd, m_kdone, MAXC);
        end
        n_checks++;
        if (nwr !== m_nwr) begin
            n_errors++;
            $display("FAIL %s write_count: got %0d expected %0d", name, nwr, m_nwr);
        end
        n_checks++;
        if (busy_bad !== 0) begin
            n_errors++;
            $display("FAIL %s busy_profile: %0d bad cycles expected 0", name, busy_bad);
        end
        n_checks++;
        if (done !== 1'b1 || la_trigger_matched !== 1'b1) begin
            n_errors++;
            $display("FAIL %s final_status: done=%b trig=%b expected 1 1", name, done, la_trigger_matched);
        end
    endtask

    task automatic check_line(input string name, input int a, input logic [23:0] e);
        n_checks++;
        if (shadow[a] !== e) begin
            n_errors++;
            $display("FAIL %s line[%0d]: got %h expected %h", name, a, shadow[a], e);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
            busy !== 1'b0 || la_trigger_matched !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s outputs: we=%b addr=%h wdata=%h busy=%b trig=%b done=%b expected all 0",
                     name, mem_we, mem_addr, mem_wdata, busy, la_trigger_matched, done);
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0; arm = 1'b0; sample = '0; trig_value = '0; trig_mask = '0; trig_edge = 1'b0;
        nwr = 0; first_addr = -1;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset_held");
        @(negedge clk) rst_l = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_idle");
    endtask

    task automatic test_counter();
        for (int k = 0; k < MAXC; k++) begin
            s[k] = {8'(k >> 1), 8'(k)}; tv[k] = 16'h0004; armx[k] = 1'b0;
        end
        t_mask = 16'h00FF; t_edge = 1'b0;
        run_capture("counter");
        check_line("counter_k", 0, {8'h01, 16'h0000});
        check_line("counter_k", 3, {8'h01, 16'h0103});
        check_line("counter_k", 8, {8'h01, 16'h0204});
        for (int a = 4; a < 8; a++) check_line("counter_unused", a, SENT);
        check_line("counter_book", 63, 24'h000003);
    endtask

    task automatic test_saturation();
        fill_random(4, 16'h00C3);
        for (int k = 0; k < 300; k++) s[k] = 16'h5A5A;
        s[300] = 16'h00C3;
        t_mask = 16'hFFFF; t_edge = 1'b0;
        run_capture("saturation");
        check_line("sat_k", 0, {8'd255, 16'h5A5A});
        check_line("sat_k", 1, {8'd45, 16'h5A5A});
    endtask

    task automatic test_sat_trigger();
        fill_random(4, 16'h3C3C);
        for (int k = 0; k < 256; k++) s[k] = 16'h3C3C;
        for (int k = 0; k < 255; k++) tv[k] = 16'h0000;
        t_mask = 16'hFFFF; t_edge = 1'b0;
        run_capture("sat_trigger");
        check_line("sat_trig_k", 0, {8'd255, 16'h3C3C});
        check_line("sat_trig_single", 1, SENT);
    endtask

    task automatic test_wrap();
        fill_random(4, 16'h0ABC);
        for (int k = 0; k <= 20; k++) s[k] = 16'h0100 + 16'(k);
        s[21] = 16'h0ABC;
        t_mask = 16'hFFFF; t_edge = 1'b0;
        run_capture("wrap");
        check_line("wrap_book", 63, {8'h00, 16'h8004});
    endtask

    task automatic test_edge();
        fill_random(4, 16'h0050);
        for (int k = 0; k < 10; k++) s[k] = 16'h1250;
        for (int k = 10; k < 15; k++) s[k] = 16'h1260;
        s[15] = 16'h7755;
        t_mask = 16'h00F0; t_edge = 1'b1;
        run_capture("edge");
        check_line("edge_flush", 1, {8'd5, 16'h1260});
    endtask

    task automatic test_reset_mid();
        fill_random(3, 16'h00C3);
        s[10] = 16'h00C3;
        trig_mask = 16'hFFFF; trig_edge = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            arm = (k == 0); sample = s[k]; trig_value = tv[k];
            @(negedge clk);
        end
        #2 rst_l = 1'b0;
        nwr = 0;
        #1 check_outputs_zero("reset_mid_async");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_l = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sample = 16'($urandom);
            @(negedge clk);
        end
        n_checks++;
        if (nwr !== 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_quiet: writes=%0d busy=%b expected 0 0", nwr, busy);
        end
        fill_random(3, 16'h00C3);
        s[12] = 16'h00C3;
        t_mask = 16'hFFFF; t_edge = 1'b0;
        run_capture("reset_restart");
        n_checks++;
        if (first_addr !== 0) begin
            n_errors++;
            $display("FAIL reset_restart_first_addr: got %0d expected 0", first_addr);
        end
    endtask

    task automatic test_arm_ignored();
        fill_random(3, 16'h00C3);
        s[30] = 16'h00C3;
        armx[40] = 1'b1;
        armx[60] = 1'b1;
        t_mask = 16'hFFFF; t_edge = 1'b0;
        run_capture("arm_in_post");
    endtask

    task automatic test_random();
        logic [15:0] tval, lsb;
        for (int r = 0; r < 4; r++) begin
            tval   = 16'($urandom);
            t_mask = 16'($urandom);
            if (t_mask == 16'h0) t_mask = 16'h0001;
            t_edge = 1'($urandom_range(0, 1));
            fill_random(3, tval);
            lsb   = t_mask & (~t_mask + 16'h0001);
            s[50] = tval ^ lsb;
            s[51] = tval;
            run_capture($sformatf("random%0d", r));
        end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_saturation();
        test_sat_trigger();
        test_wrap();
        test_edge();
        test_reset_mid();
        test_arm_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_verifla_capture_rle
